sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter MEM_AW, default 12: address bits of the internal backing array (2^MEM_AW 16-bit words).
REQ-002 Parameter DEF_CL, default 3: CAS latency used before the first LOAD MODE.
REQ-003 CLK  in  1  single clock; all activity on rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SA  in  12  row/column/mode address.
REQ-006 BA  in  2  bank select.
REQ-007 CS_N  in  2  chip selects; only CS_N[0] is decoded.
REQ-008 CKE  in  1  clock enable; 0 = command ignored, bursts frozen.
REQ-009 RAS_N, CAS_N, WE_N  in  1 each  command strobes.
REQ-010 DQM  in  2  byte masks (bit1 = DQ[15:8]).
REQ-011 DQ  inout  16  data bus; driven only during read data cycles, else high-Z.
REQ-012 ERR  out  4  sticky protocol-error flags.
REQ-013 MODE_OK  out  1  high once a LOAD MODE has been accepted.

Function
REQ-014 Command valid when CKE=1 and CS_N[0]=0; {RAS_N,CAS_N,WE_N}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 110 BURST TERMINATE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE.
REQ-015 LOAD MODE: CL = SA[6:4] (values 2, 3 accepted; other values keep the old CL and set ERR[2]); BL = SA[2:0] (0->1, 1->2, 2->4, 3->8, 7->full page 256); MODE_OK <= 1.
REQ-016 Per-bank state IDLE/ACTIVE plus a 12-bit row register; ACTIVE latches SA into the row register and moves the bank to ACTIVE.
REQ-017 PRECHARGE: SA[10]=1 idles all banks; SA[10]=0 idles bank BA only.
REQ-018 Word address = {BA, row, column[7:0]} truncated to its low MEM_AW bits.
REQ-019 Burst column counter increments by 1 per word and wraps 255->0 inside the page; bursts of length BL < 256 wrap on BL alignment.
REQ-020 WRITE: first word captured on the WRITE edge from DQ at SA[7:0], continuing for BL words; a DQM bit at 1 leaves that byte unchanged.
REQ-021 READ: first word is driven on DQ exactly CL cycles after the READ edge, one word per cycle for BL words, then high-Z.
REQ-022 Read DQM masking has 2-cycle latency: DQM[b]=1 at edge n tristates byte b of the word driven at edge n+2.
REQ-023 BURST TERMINATE: a write stops immediately; a read drives its last word CL-1 cycles after the BST edge.
REQ-024 A new READ or WRITE during an active burst truncates the old burst; read data already in the CL pipeline still completes.
REQ-025 Read-after-write and write-after-read to the same word return the new data with no extra latency.
REQ-026 CKE=0 freezes the burst counters and the CL pipeline; DQ holds its current drive state.
REQ-027 Error flags, set-only: ERR[0] READ/WRITE to an IDLE bank (command ignored); ERR[1] ACTIVE to an ACTIVE bank (row overwritten); ERR[2] READ/WRITE/ACTIVE before MODE_OK, or an invalid CL; ERR[3] AUTO REFRESH with any bank ACTIVE.
REQ-028 AUTO REFRESH has no effect on data contents.
REQ-029 An implementation of 120-400 lines is expected; the backing array infers RAM.

Reset
REQ-030 RESET_N=0, asynchronous: all banks IDLE, CL=DEF_CL, BL=256, MODE_OK=0, ERR=0, bursts cancelled, DQ high-Z; memory contents undefined.
REQ-031 Reset assertion mid-burst releases DQ to high-Z within the same cycle.

Verification
REQ-032 LOAD MODE SA=0x037, ACTIVE bank0 row 0x005, WRITE col 0x10 with 4 words 0xA001..0xA004, BST, READ col 0x10 -> 0xA001 appears 3 cycles after READ, then 0xA002, 0xA003, 0xA004 before BST cuts the burst; ERR=0.
REQ-033 CL=2 (SA=0x027), full-page write starting at col 0xFE with 3 words -> a read from col 0x00 returns the third word (page wrap).
REQ-034 Write 0xFFFF, then write 0x1234 with DQM=2'b10 -> read returns 0xFF34; a read with DQM=2'b01 at edge n leaves DQ[7:0] high-Z at edge n+2.
REQ-035 READ to an idle bank -> ERR[0]=1, DQ stays high-Z; ACTIVE issued twice -> ERR[1]=1; READ before LOAD MODE -> ERR[2]=1; AUTO REFRESH with bank 2 active -> ERR[3]=1.
REQ-036 Full-page read in progress, RESET_N pulled low -> DQ high-Z immediately, MODE_OK=0, ERR=0.
REQ-037 Back-to-back sequence: write a burst of 256 words from the 4-port SDRAM controller, read it back -> data matches word for word, with the read burst ended by a BST issued at CL+256.

Source files
------------

// File: rtl/sdram_responder.sv
// Behavioural single-chip SDRAM model: decodes controller commands, tracks bank/row state and
// serves read/write bursts from an internal RAM with programmable CAS latency and burst length.
module sdram_responder #(
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned DEF_CL = 3
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [11:0] SA,
    input  logic [1:0]  BA,
    input  logic [1:0]  CS_N,
    input  logic        CKE,
    input  logic        RAS_N,
    input  logic        CAS_N,
    input  logic        WE_N,
    input  logic [1:0]  DQM,
    inout  wire  [15:0] DQ,
    output logic [3:0]  ERR,
    output logic        MODE_OK
);

    typedef enum logic {BankIdle, BankActive} bank_state_e;

    localparam logic [2:0] CmdNop    = 3'b111;
    localparam logic [2:0] CmdActive = 3'b011;
    localparam logic [2:0] CmdRead   = 3'b101;
    localparam logic [2:0] CmdWrite  = 3'b100;
    localparam logic [2:0] CmdBst    = 3'b110;
    localparam logic [2:0] CmdPre    = 3'b010;
    localparam logic [2:0] CmdRef    = 3'b001;
    localparam logic [2:0] CmdLmr    = 3'b000;

    bank_state_e bank_q [4];
    bank_state_e bank_d [4];
    logic [11:0] row_q [4];
    logic [11:0] row_d [4];
    logic [2:0]  cl_q, cl_d;
    logic [7:0]  bl_mask_q, bl_mask_d;
    logic        mode_ok_q, mode_ok_d;
    logic [3:0]  err_q, err_d;
    logic        burst_q, burst_d;
    logic        burst_rd_q, burst_rd_d;
    logic [13:0] page_q, page_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  rem_q, rem_d;

    logic        cmd_en, new_burst, acc_en, acc_wr;
    logic [2:0]  cmd;
    logic [13:0] acc_page;
    logic [7:0]  acc_col;
    logic [21:0] addr_full;
    logic [MEM_AW-1:0] mem_addr;

    logic [15:0] mem [2**MEM_AW];
    logic [15:0] rd_data_q, pd2_q, pd3_q, dq_q;
    logic [2:0]  pv_q;
    logic [1:0]  dqm_p1_q, dqm_p2_q, oe_q;
    logic        unused_bits;

    // Burst column advance: wraps inside the BL-aligned block (whole page for full-page bursts).
    function automatic logic [7:0] next_col(input logic [7:0] c, input logic [7:0] m);
        return (c & ~m) | ((c + 8'd1) & m);
    endfunction

    assign cmd_en    = CKE & ~CS_N[0];
    assign cmd       = {RAS_N, CAS_N, WE_N};
    assign addr_full = {acc_page, acc_col};
    assign mem_addr  = addr_full[MEM_AW-1:0];
    assign unused_bits = ^{CS_N[1], addr_full};

    always_comb begin
        bank_d    = bank_q;
        row_d     = row_q;
        cl_d      = cl_q;
        bl_mask_d = bl_mask_q;
        mode_ok_d = mode_ok_q;
        err_d     = err_q;
        burst_d   = burst_q;
        burst_rd_d = burst_rd_q;
        page_d    = page_q;
        col_d     = col_q;
        rem_d     = rem_q;
        new_burst = 1'b0;
        acc_en    = 1'b0;
        acc_wr    = 1'b0;
        acc_page  = page_q;
        acc_col   = col_q;
        if (CKE) begin
            if (burst_q) begin
                acc_en = 1'b1;
                acc_wr = ~burst_rd_q;
            end
            if (cmd_en) begin
                unique case (cmd)
                    CmdNop: ;
                    CmdActive: begin
                        if (bank_q[BA] == BankActive) err_d[1] = 1'b1;
                        if (!mode_ok_q) err_d[2] = 1'b1;
                        bank_d[BA] = BankActive;
                        row_d[BA]  = SA;
                    end
                    CmdRead, CmdWrite: begin
                        if (!mode_ok_q) err_d[2] = 1'b1;
                        if (bank_q[BA] == BankIdle) begin
                            err_d[0] = 1'b1;
                        end else begin
                            new_burst = 1'b1;
                            acc_en    = 1'b1;
                            acc_wr    = (cmd == CmdWrite);
                            acc_page  = {BA, row_q[BA]};
                            acc_col   = SA[7:0];
                        end
                    end
                    CmdBst: begin
                        acc_en  = 1'b0;
                        burst_d = 1'b0;
                    end
                    CmdPre: begin
                        if (SA[10]) begin
                            for (int i = 0; i < 4; i++) bank_d[i] = BankIdle;
                        end else begin
                            bank_d[BA] = BankIdle;
                        end
                    end
                    CmdRef: begin
                        for (int i = 0; i < 4; i++) begin
                            if (bank_q[i] == BankActive) err_d[3] = 1'b1;
                        end
                    end
                    CmdLmr: begin
                        if (SA[6:4] == 3'd2 || SA[6:4] == 3'd3) cl_d = SA[6:4];
                        else err_d[2] = 1'b1;
                        case (SA[2:0])
                            3'd0:    bl_mask_d = 8'h00;
                            3'd1:    bl_mask_d = 8'h01;
                            3'd2:    bl_mask_d = 8'h03;
                            3'd3:    bl_mask_d = 8'h07;
                            3'd7:    bl_mask_d = 8'hFF;
                            default: bl_mask_d = bl_mask_q;
                        endcase
                        mode_ok_d = 1'b1;
                    end
                endcase
            end
            if (new_burst) begin
                burst_d    = (bl_mask_q != 8'h00);
                burst_rd_d = ~acc_wr;
                page_d     = acc_page;
                col_d      = next_col(acc_col, bl_mask_q);
                rem_d      = bl_mask_q;
            end else if (acc_en) begin
                col_d = next_col(col_q, bl_mask_q);
                // Full-page bursts run until terminated; shorter ones count down.
                if (bl_mask_q != 8'hFF) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) burst_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= BankIdle;
                row_q[i]  <= 12'h000;
            end
            cl_q       <= DEF_CL[2:0];
            bl_mask_q  <= 8'hFF;
            mode_ok_q  <= 1'b0;
            err_q      <= 4'h0;
            burst_q    <= 1'b0;
            burst_rd_q <= 1'b0;
            page_q     <= 14'h0;
            col_q      <= 8'h00;
            rem_q      <= 8'h00;
        end else begin
            bank_q     <= bank_d;
            row_q      <= row_d;
            cl_q       <= cl_d;
            bl_mask_q  <= bl_mask_d;
            mode_ok_q  <= mode_ok_d;
            err_q      <= err_d;
            burst_q    <= burst_d;
            burst_rd_q <= burst_rd_d;
            page_q     <= page_d;
            col_q      <= col_d;
            rem_q      <= rem_d;
        end
    end

    // Backing RAM with byte-masked writes and a registered read port (first CL stage).
    always_ff @(posedge CLK) begin
        if (acc_en && acc_wr) begin
            if (!DQM[0]) mem[mem_addr][7:0]  <= DQ[7:0];
            if (!DQM[1]) mem[mem_addr][15:8] <= DQ[15:8];
        end
        if (acc_en && !acc_wr) rd_data_q <= mem[mem_addr];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pv_q     <= 3'b000;
            pd2_q    <= 16'h0000;
            pd3_q    <= 16'h0000;
            dqm_p1_q <= 2'b00;
            dqm_p2_q <= 2'b00;
            dq_q     <= 16'h0000;
            oe_q     <= 2'b00;
        end else if (CKE) begin
            pv_q     <= {pv_q[1:0], acc_en & ~acc_wr};
            pd2_q    <= rd_data_q;
            pd3_q    <= pd2_q;
            dqm_p1_q <= DQM;
            dqm_p2_q <= dqm_p1_q;
            if (cl_q == 3'd2) begin
                dq_q <= pd2_q;
                oe_q <= {2{pv_q[1]}} & ~dqm_p2_q;
            end else begin
                dq_q <= pd3_q;
                oe_q <= {2{pv_q[2]}} & ~dqm_p2_q;
            end
        end
    end

    assign DQ[7:0]  = oe_q[0] ? dq_q[7:0]  : 8'hzz;
    assign DQ[15:8] = oe_q[1] ? dq_q[15:8] : 8'hzz;
    assign ERR      = err_q;
    assign MODE_OK  = mode_ok_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder; the data bus is pulled up so a released byte reads as 8'hFF.
module tb_sdram_responder;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
    localparam logic [2:0] C_BST = 3'b110, C_REF = 3'b001, C_LMR = 3'b000;
    localparam logic [15:0] ZBUS = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sa;
    logic [1:0]  ba, cs_n, dqm;
    logic        cke, ras_n, cas_n, we_n;
    logic [15:0] dq_drv;
    logic        dq_en;
    wire  [15:0] dq;
    logic [3:0]  err;
    logic        mode_ok;
    int          checks = 0;
    int          errors = 0;

    assign dq = dq_en ? dq_drv : 16'hzzzz;
    pullup pu[15:0] (dq);

    sdram_responder dut (
        .CLK(clk), .RESET_N(rst_n), .SA(sa), .BA(ba), .CS_N(cs_n), .CKE(cke),
        .RAS_N(ras_n), .CAS_N(cas_n), .WE_N(we_n), .DQM(dqm), .DQ(dq),
        .ERR(err), .MODE_OK(mode_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
        {ras_n, cas_n, we_n} = c;
        ba   = b;
        sa   = a;
        cs_n = 2'b10;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wd(input int i);
        return 16'(i * 257) ^ 16'hC3A5;
    endfunction

    initial begin
        rst_n = 1'b0; cke = 1'b1; dqm = 2'b00; dq_en = 1'b0; dq_drv = 16'h0;
        cmd(C_NOP, 2'd0, 12'h000);
        #2;
        chk("reset_dq", dq, ZBUS);
        chk("reset_mode_ok", {15'd0, mode_ok}, 16'd0);
        chk("reset_err", {12'd0, err}, 16'd0);
        tick(); tick();
        rst_n = 1'b1;

        // READ before LOAD MODE to an idle bank
        cmd(C_RD, 2'd0, 12'h000); tick();
        cmd(C_NOP, 2'd0, 12'h000); tick(); tick(); tick();
        chk("err_before_mode", {12'd0, err}, 16'h0005);
        chk("dq_z_before_mode", dq, ZBUS);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("err_cleared", {12'd0, err}, 16'd0);

        // CL=3 full page, write 4 words, BST, read back
        cmd(C_LMR, 2'd0, 12'h037); tick();
        chk("mode_ok_set", {15'd0, mode_ok}, 16'd1);
        cmd(C_ACT, 2'd0, 12'h005); tick();
        dq_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) cmd(C_WR, 2'd0, 12'h010);
            else cmd(C_NOP, 2'd0, 12'h000);
            dq_drv = 16'hA001 + 16'(i);
            tick();
        end
        dq_en = 1'b0;
        cmd(C_BST, 2'd0, 12'h000); tick();
        cmd(C_RD, 2'd0, 12'h010); tick();
        cmd(C_NOP, 2'd0, 12'h000); tick(); tick();
        chk("cl3_not_early", dq, ZBUS);
        tick();
        chk("cl3_word0", dq, 16'hA001);
        cmd(C_BST, 2'd0, 12'h000); tick();
        chk("cl3_word1", dq, 16'hA002);
        cmd(C_NOP, 2'd0, 12'h000); tick();
        chk("cl3_word2", dq, 16'hA003);
        tick();
        chk("cl3_word3", dq, 16'hA004);
        tick();
        chk("bst_release", dq, ZBUS);
        chk("err_clean", {12'd0, err}, 16'd0);

        // CL=2 full page write across the page end
        cmd(C_LMR, 2'd0, 12'h027); tick();
        dq_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) cmd(C_WR, 2'd0, 12'h0FE);
            else cmd(C_NOP, 2'd0, 12'h000);
            dq_drv = 16'hB001 + 16'(i);
            tick();
        end
        dq_en = 1'b0;
        cmd(C_BST, 2'd0, 12'h000); tick();
        cmd(C_RD, 2'd0, 12'h000); tick();
        cmd(C_BST, 2'd0, 12'h000); tick();
        chk("cl2_not_early", dq, ZBUS);
        cmd(C_NOP, 2'd0, 12'h000); tick();
        chk("page_wrap", dq, 16'hB003);
        tick();
        chk("cl2_bst_release", dq, ZBUS);

        // CL=2 BL=1: byte-masked write, read-after-write, CKE freeze, read DQM latency
        cmd(C_LMR, 2'd0, 12'h020); tick();
        dq_en = 1'b1;
        cmd(C_WR, 2'd0, 12'h020); dq_drv = 16'hFFFF; tick();
        cmd(C_WR, 2'd0, 12'h020); dq_drv = 16'h1234; dqm = 2'b10; tick();
        cmd(C_WR, 2'd0, 12'h021); dq_drv = 16'h1234; dqm = 2'b00; tick();
        dq_en = 1'b0;
        cmd(C_RD, 2'd0, 12'h020); tick();
        cmd(C_NOP, 2'd0, 12'h000); cke = 1'b0; tick();
        cke = 1'b1; tick();
        chk("cke_freeze", dq, ZBUS);
        tick();
        chk("masked_write", dq, 16'hFF34);
        tick();
        chk("bl1_release", dq, ZBUS);
        cmd(C_RD, 2'd0, 12'h021); dqm = 2'b01; tick();
        cmd(C_NOP, 2'd0, 12'h000); dqm = 2'b00; tick(); tick();
        chk("read_dqm_lat2", dq, 16'h12FF);

        // Error flags
        cmd(C_RD, 2'd1, 12'h000); tick();
        cmd(C_NOP, 2'd0, 12'h000); tick(); tick(); tick();
        chk("err0_idle_read", {12'd0, err}, 16'h0001);
        chk("idle_read_dq_z", dq, ZBUS);
        cmd(C_ACT, 2'd2, 12'h001); tick();
        chk("err_first_act", {12'd0, err}, 16'h0001);
        cmd(C_ACT, 2'd2, 12'h002); tick();
        chk("err1_double_act", {12'd0, err}, 16'h0003);
        cmd(C_REF, 2'd0, 12'h000); tick();
        chk("err3_refresh", {12'd0, err}, 16'h000B);

        // Reset during a full-page read
        cmd(C_LMR, 2'd0, 12'h037); tick();
        cmd(C_RD, 2'd0, 12'h000); tick();
        cmd(C_NOP, 2'd0, 12'h000); tick(); tick(); tick();
        chk("fp_read_driving", dq, 16'hB003);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_dq_release", dq, ZBUS);
        chk("rst_mode_ok", {15'd0, mode_ok}, 16'd0);
        chk("rst_err", {12'd0, err}, 16'd0);
        tick(); rst_n = 1'b1;

        // 256-word burst write and read back
        cmd(C_LMR, 2'd0, 12'h037); tick();
        cmd(C_ACT, 2'd1, 12'h0AB); tick();
        dq_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 0) cmd(C_WR, 2'd1, 12'h000);
            else cmd(C_NOP, 2'd0, 12'h000);
            dq_drv = wd(i);
            tick();
        end
        dq_en = 1'b0;
        cmd(C_BST, 2'd0, 12'h000); tick();
        cmd(C_RD, 2'd1, 12'h000); tick();
        for (int k = 1; k <= 262; k++) begin
            if (k == 259) cmd(C_BST, 2'd0, 12'h000);
            else cmd(C_NOP, 2'd0, 12'h000);
            tick();
            if (k == 2) chk("fp_not_early", dq, ZBUS);
            if (k >= 3 && k <= 258) chk($sformatf("fp_word%0d", k - 3), dq, wd(k - 3));
            if (k == 262) chk("fp_bst_release", dq, ZBUS);
        end
        chk("final_err", {12'd0, err}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
